// File: rtl/dcache_direct_wt_if.sv
// Datapath <-> data cache request/response bundle.
interface cache_if;
  logic        read;
  logic [1:0]  write;
  logic [31:0] addr;
  logic [31:0] store;
  logic        done;
  logic        ready;
  logic [31:0] load;

  modport cache    (input read, write, addr, store, done, output ready, load);
  modport datapath (output read, write, addr, store, done, input ready, load);
endinterface

// File: rtl/dcache_direct_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Hits answer combinationally in IDLE; misses and all writes go over the mem bus.
module dcache_direct_wt #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        nrst,
  cache_if.cache      cif,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, HOLD} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES];
  logic [31:0]            hold_data;

  logic [IDX_W-1:0]       idx_c;
  logic [TAG_W-1:0]       tag_c;
  logic                   hit_c;
  logic                   idle_hit_c;
  logic [3:0]             strb_c;
  logic [31:0]            wdata_c;
  logic [31:0]            merged_c;

  assign idx_c      = cif.addr[IDX_W+1:2];
  assign tag_c      = cif.addr[31:IDX_W+2];
  assign hit_c      = valid[idx_c] && (tag_mem[idx_c] == tag_c);
  assign idle_hit_c = (state == IDLE) && (cif.write == 2'd0) && cif.read && hit_c;

  assign cif.ready  = (state == HOLD) || idle_hit_c;
  assign cif.load   = (state == HOLD) ? hold_data :
                      (idle_hit_c ? data_mem[idx_c] : 32'd0);

  // Byte-lane placement of store data for the requested write size.
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = cif.store;
    case (cif.write)
      2'd1: begin
        strb_c  = 4'b0001 << cif.addr[1:0];
        wdata_c = {4{cif.store[7:0]}};
      end
      2'd2: begin
        strb_c  = 4'b0011 << {cif.addr[1], 1'b0};
        wdata_c = {2{cif.store[15:0]}};
      end
      default: ;
    endcase
  end

  // Write-hit update uses exactly the lanes sent downstream.
  always_comb begin
    merged_c = data_mem[idx_c];
    for (int b = 0; b < 4; b++) begin
      if (mem_strb[b]) merged_c[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_strb  <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      hold_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cif.write != 2'd0) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_wen   <= 1'b1;
            mem_strb  <= strb_c;
            mem_wdata <= wdata_c;
            mem_addr  <= {cif.addr[31:2], 2'b00};
          end else if (cif.read && !hit_c) begin
            state     <= FILL;
            mem_req   <= 1'b1;
            mem_wen   <= 1'b0;
            mem_strb  <= 4'b1111;
            mem_addr  <= {cif.addr[31:2], 2'b00};
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid[idx_c] <= 1'b1;
            hold_data    <= mem_rdata;
            mem_req      <= 1'b0;
            state        <= HOLD;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cif.done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage; validity lives in the reset domain above.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ready) begin
      tag_mem[idx_c]  <= tag_c;
      data_mem[idx_c] <= mem_rdata;
    end else if (state == WRITE && mem_ready && hit_c) begin
      data_mem[idx_c] <= merged_c;
    end
  end

endmodule

// File: tb/tb_dcache_direct_wt.sv
// Randomized bench for dcache_direct_wt against an array-based cache/lane model.
module tb_dcache_direct_wt;

  logic        clk = 1'b0;
  logic        nrst;
  logic        mem_req, mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  cache_if cif ();

  dcache_direct_wt #(.NUM_LINES(16)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cif       (cif.cache),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference cache contents, indexed by word address modulo the line count.
  bit          mv [16];
  int unsigned mt [16];
  logic [31:0] md [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / 64;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s;
    case (sz)
      2'd1:    s = 4'(1 << (a % 4));
      2'd2:    s = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] st);
    logic [31:0] w;
    case (sz)
      2'd1:    w = (st & 32'hFF) * 32'h0101_0101;
      2'd2:    w = (st & 32'hFFFF) * 32'h0001_0001;
      default: w = st;
    endcase
    return w;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[line_of(a)] && (mt[line_of(a)] == tag_of(a));
  endfunction

  // Memory responder: waits for mem_req, stalls 'waits' cycles, completes.
  task automatic serve(input int waits, input logic [31:0] rd, output int reqcyc,
                       output logic wen, output logic [3:0] strb,
                       output logic [31:0] addr, output logic [31:0] wdata);
    int t = 0;
    reqcyc = 0; wen = 1'b0; strb = 4'b0; addr = 32'd0; wdata = 32'd0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!mem_req) begin
      check("mem_req_timeout", 32'(mem_req), 32'd1);
      return;
    end
    reqcyc = 1;
    repeat (waits) begin
      @(negedge clk);
      if (mem_req) reqcyc++;
    end
    wen = mem_wen; strb = mem_strb; addr = mem_addr; wdata = mem_wdata;
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    check("mem_req_drop", 32'(mem_req), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int waits, input logic [31:0] rd,
                         output bit hit, output int reqcyc);
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] maddr, wd;
    int unsigned i = line_of(a);
    hit = model_hit(a);
    reqcyc = 0;
    @(negedge clk);
    cif.read = 1'b1; cif.write = 2'd0; cif.addr = a; cif.done = 1'b0;
    #1;
    check("rd_idle_ready", 32'(cif.ready), 32'(hit));
    if (hit) begin
      check("rd_hit_load", cif.load, md[i]);
      @(negedge clk);
      check("rd_hit_noreq", 32'(mem_req), 32'd0);
      cif.read = 1'b0;
    end else begin
      serve(waits, rd, reqcyc, wen, strb, maddr, wd);
      check("fill_wen", 32'(wen), 32'd0);
      check("fill_strb", 32'(strb), 32'hF);
      check("fill_addr", maddr, a & 32'hFFFF_FFFC);
      check("fill_ready", 32'(cif.ready), 32'd1);
      check("fill_load", cif.load, rd);
      mv[i] = 1'b1; mt[i] = tag_of(a); md[i] = rd;
      cif.done = 1'b1;
      @(negedge clk);
      cif.read = 1'b0; cif.done = 1'b0;
      #1;
      check("fill_release", 32'(cif.ready), 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] st,
                          input bit rd_too, input int waits,
                          output logic [3:0] strb, output logic [31:0] wd, output logic wen);
    logic [31:0] maddr;
    logic [3:0]  es;
    logic [31:0] ew;
    int          reqcyc;
    int unsigned i = line_of(a);
    es = ref_strb(sz, a);
    ew = ref_wdata(sz, st);
    @(negedge clk);
    cif.read = rd_too; cif.write = sz; cif.addr = a; cif.store = st; cif.done = 1'b0;
    #1;
    check("wr_idle_ready", 32'(cif.ready), 32'd0);
    serve(waits, $urandom, reqcyc, wen, strb, maddr, wd);
    check("wr_wen", 32'(wen), 32'd1);
    check("wr_strb", 32'(strb), 32'(es));
    check("wr_wdata", wd, ew);
    check("wr_addr", maddr, a & 32'hFFFF_FFFC);
    check("wr_hold_ready", 32'(cif.ready), 32'd1);
    if (model_hit(a)) begin
      for (int b = 0; b < 4; b++)
        if (es[b]) md[i][8*b +: 8] = ew[8*b +: 8];
    end
    cif.done = 1'b1;
    @(negedge clk);
    cif.read = 1'b0; cif.write = 2'd0; cif.done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hit;
    int          reqcyc;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        wen;

    nrst = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    cif.read = 1'b0; cif.write = 2'd0; cif.addr = 32'd0; cif.store = 32'd0; cif.done = 1'b0;
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = 0; md[i] = 32'd0; end
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_strb", 32'(mem_strb), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ready", 32'(cif.ready), 32'd0);
    check("rst_load", cif.load, 32'd0);
    nrst = 1'b1;

    // Cold read with three wait cycles, then same-address hit.
    do_read(32'h40, 3, 32'hDEAD_BEEF, hit, reqcyc);
    check("cold_miss", 32'(hit), 32'd0);
    check("cold_req_cycles", 32'(reqcyc), 32'd4);
    do_read(32'h40, 0, 32'd0, hit, reqcyc);
    check("reread_hit", 32'(hit), 32'd1);

    // Byte write into a cached line merges the lane.
    do_write(32'h42, 2'd1, 32'h0000_00AB, 1'b0, 1, strb, wd, wen);
    check("bw_strb", 32'(strb), 32'h4);
    check("bw_wdata", wd, 32'hABAB_ABAB);
    do_read(32'h40, 0, 32'd0, hit, reqcyc);
    check("bw_hit", 32'(hit), 32'd1);
    check("bw_merged", md[line_of(32'h40)], 32'hDEAB_BEEF);

    // Halfword write miss does not allocate.
    do_write(32'h82, 2'd2, 32'h0000_1234, 1'b0, 2, strb, wd, wen);
    check("hw_strb", 32'(strb), 32'hC);
    check("hw_wdata", wd, 32'h1234_1234);
    do_read(32'h80, 1, 32'h5555_AAAA, hit, reqcyc);
    check("hw_no_alloc", 32'(hit), 32'd0);

    // Conflict on line 0.
    do_read(32'h440, 0, 32'h0440_0440, hit, reqcyc);
    check("conf_b_miss", 32'(hit), 32'd0);
    do_read(32'h040, 2, 32'hDEAB_BEEF, hit, reqcyc);
    check("conf_a_miss", 32'(hit), 32'd0);

    // Simultaneous read and write: write wins.
    do_write(32'h100, 2'd3, 32'hCAFE_F00D, 1'b1, 0, strb, wd, wen);
    check("rw_wen", 32'(wen), 32'd1);
    check("rw_strb", 32'(strb), 32'hF);
    check("rw_wdata", wd, 32'hCAFE_F00D);

    // Reset during a fill.
    @(negedge clk);
    cif.read = 1'b1; cif.addr = 32'h200;
    repeat (2) @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("rst_fill_req", 32'(mem_req), 32'd0);
    check("rst_fill_ready", 32'(cif.ready), 32'd0);
    @(negedge clk);
    cif.read = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    do_read(32'h040, 1, 32'h1357_9BDF, hit, reqcyc);
    check("post_rst_miss", 32'(hit), 32'd0);

    // Random traffic over a small address pool to provoke hits and conflicts.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      int          op;
      a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      if (op == 0) do_read(a, $urandom_range(0, 3), $urandom, hit, reqcyc);
      else do_write(a, 2'(op), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    strb, wd, wen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
